apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master_pkg.sv | 21 ++
 rtl/apb_cmd_master_wdog.sv | 29 ++
 rtl/apb_cmd_master.sv | 118 +++++++++++
 tb/tb_apb_cmd_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master: FSM encoding,
// response codes and the slave-select decode.
package apb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  // Address bits [27:24] pick one of sixteen slaves.
  function automatic logic [15:0] psel_decode(input logic [31:0] addr);
    return 16'h0001 << addr[27:24];
  endfunction

endpackage

// File: rtl/apb_cmd_master_wdog.sv
// Wait-state watchdog: counts stalled ACCESS cycles and flags the cycle whose
// increment would bring the count to LIMIT.
module apb_cmd_master_wdog #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: accepts one command at a time, runs a single APB
// transfer with wait-state timeout, and returns data/status on a response port.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned APB_DWIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [31:0]           CMD_ADDR,
  input  logic [APB_DWIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [APB_DWIDTH-1:0] RSP_RDATA,
  output logic [1:0]            RSP_ERR,
  output logic [31:0]           PADDR,
  output logic [15:0]           PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DWIDTH-1:0] PWDATA,
  input  logic [APB_DWIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_t state;
  logic   cmd_accept;
  logic   wait_cycle;
  logic   expired;

  // CMD_READY is itself part of the accept term, so nothing is taken in the
  // first cycle after reset release while CMD_READY is still low.
  assign cmd_accept = (state == ST_IDLE) && CMD_READY && CMD_VALID;
  assign wait_cycle = (state == ST_ACCESS) && !PREADY;

  apb_cmd_master_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .clear   (cmd_accept),
    .enable  (wait_cycle),
    .expired (expired)
  );

  // NOTE: every output register is in the async reset branch, so a reset
  // mid-transfer drops the bus and the pending response at once.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state     <= ST_IDLE;
      CMD_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= RSP_OK;
      PADDR     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_accept) begin
            state     <= ST_SETUP;
            CMD_READY <= 1'b0;
            PSEL      <= psel_decode(CMD_ADDR);
            PADDR     <= CMD_ADDR;
            PWRITE    <= CMD_WRITE;
            PWDATA    <= CMD_WDATA;
          end else begin
            CMD_READY <= 1'b1;
          end
        end

        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end

        ST_ACCESS: begin
          // A ready slave wins over a watchdog expiring on the same edge.
          if (PREADY) begin
            state     <= ST_RESP;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_RDATA <= PWRITE ? '0 : PRDATA;
            RSP_ERR   <= PSLVERR ? RSP_SLVERR : RSP_OK;
          end else if (expired) begin
            state     <= ST_RESP;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            RSP_VALID <= 1'b1;
            RSP_RDATA <= '0;
            RSP_ERR   <= RSP_TIMEOUT;
          end
        end

        ST_RESP: begin
          if (RSP_READY) begin
            state     <= ST_IDLE;
            RSP_VALID <= 1'b0;
            CMD_READY <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: bus-phase timing, wait states, slave
// error, timeout boundary, back-to-back, response stall and mid-transfer reset.
module tb_apb_cmd_master;

  logic        PCLK;
  logic        PRESETN;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDR;
  logic [31:0] CMD_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_RDATA;
  logic [1:0]  RSP_ERR;
  logic [31:0] PADDR;
  logic [15:0] PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_cmd_master #(
    .APB_DWIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_WRITE (CMD_WRITE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_WDATA (CMD_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer; the slave stalls for 'waits' ACCESS cycles.
  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                      input logic slverr, input logic [15:0] exp_sel, input logic [1:0] exp_err,
                      input logic [31:0] exp_rdata, input int exp_access);
    int access;
    for (int i = 0; i < 10 && !CMD_READY; i++) tick();
    check({name, "_cmd_ready"}, CMD_READY, 1'b1);
    CMD_VALID = 1'b1;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wdata;
    tick();
    // Scramble the command port; the bus must keep the latched values.
    CMD_VALID = 1'b0;
    CMD_WRITE = ~wr;
    CMD_ADDR  = ~addr;
    CMD_WDATA = ~wdata;
    check({name, "_setup_psel"}, PSEL, exp_sel);
    check({name, "_setup_penable"}, PENABLE, 1'b0);
    check({name, "_setup_paddr"}, PADDR, addr);
    check({name, "_setup_pwrite"}, PWRITE, wr);
    check({name, "_setup_pwdata"}, PWDATA, wdata);
    check({name, "_busy_cmd_ready"}, CMD_READY, 1'b0);
    tick();
    check({name, "_access_penable"}, PENABLE, 1'b1);
    check({name, "_access_psel"}, PSEL, exp_sel);
    check({name, "_access_paddr"}, PADDR, addr);
    check({name, "_access_pwdata"}, PWDATA, wdata);
    access = 0;
    while (PENABLE && access < 40) begin
      access++;
      PREADY  = (access > waits);
      PRDATA  = PREADY ? rdata : (32'hBAD0_0000 | 32'(access));
      PSLVERR = slverr && PREADY;
      tick();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'hFFFF_0000;
    check({name, "_access_len"}, 64'(access), 64'(exp_access));
    check({name, "_rsp_valid"}, RSP_VALID, 1'b1);
    check({name, "_rsp_psel"}, PSEL, 16'h0000);
    check({name, "_rsp_err"}, RSP_ERR, exp_err);
    check({name, "_rsp_rdata"}, RSP_RDATA, exp_rdata);
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    check({name, "_done_rsp_valid"}, RSP_VALID, 1'b0);
    check({name, "_done_cmd_ready"}, CMD_READY, 1'b1);
    check({name, "_idle_paddr_kept"}, PADDR, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int rise_cnt;
    int rise1;
    int rise2;
    logic [15:0] prev_sel;
    logic stable_ok;
    logic seen_activity;

    PRESETN   = 1'b0;
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = '0;
    CMD_WDATA = '0;
    RSP_READY = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset state: everything zero, CMD_READY rises on the first edge after release.
    repeat (3) tick();
    check("rst_psel", PSEL, 16'h0000);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_rsp_valid", RSP_VALID, 1'b0);
    check("rst_rsp_rdata", RSP_RDATA, 32'h0);
    check("rst_rsp_err", RSP_ERR, 2'b00);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_cmd_ready", CMD_READY, 1'b0);
    #2 PRESETN = 1'b1;
    check("rel_cmd_ready_before_edge", CMD_READY, 1'b0);
    tick();
    check("rel_cmd_ready_after_edge", CMD_READY, 1'b1);

    // Zero-wait write: slave 3, read data forced to zero.
    xfer("wr0", 1'b1, 32'h0300_0004, 32'hA5A5_0001, 0, 32'hFFFF_FFFF, 1'b0,
         16'h0008, 2'b00, 32'h0, 1);
    // Read with three wait states.
    xfer("rd3", 1'b0, 32'h0000_0010, 32'h0, 3, 32'h1234_5678, 1'b0,
         16'h0001, 2'b00, 32'h1234_5678, 4);
    // Slave error on slave 15.
    xfer("slverr", 1'b0, 32'h0F00_0020, 32'h0, 0, 32'hDEAD_BEEF, 1'b1,
         16'h8000, 2'b01, 32'hDEAD_BEEF, 1);
    // Stuck slave: aborts after four wait cycles with zero data.
    xfer("tmo", 1'b0, 32'h0500_0000, 32'h0, 1000, 32'h0, 1'b0,
         16'h0020, 2'b10, 32'h0, 4);
    // Ready on the edge the counter would hit the limit: completes normally.
    xfer("tmo_edge", 1'b0, 32'h0A00_0000, 32'h0, 3, 32'h0BAD_F00D, 1'b0,
         16'h0400, 2'b00, 32'h0BAD_F00D, 4);

    // Back-to-back with RSP_READY tied high. SETUP, ACCESS, RESP, IDLE take one
    // cycle each, so counting the first select cycle as 1 the second lands on 5.
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 32'h0100_0000;
    CMD_WDATA = 32'h0000_00B2;
    RSP_READY = 1'b1;
    PREADY    = 1'b1;
    rise_cnt  = 0;
    rise1     = -1;
    rise2     = -1;
    prev_sel  = PSEL;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (PSEL != 16'h0 && prev_sel == 16'h0) begin
        rise_cnt++;
        if (rise_cnt == 1) rise1 = i;
        if (rise_cnt == 2) begin
          rise2 = i;
          CMD_VALID = 1'b0;
        end
      end
      prev_sel = PSEL;
    end
    RSP_READY = 1'b0;
    PREADY    = 1'b0;
    check("b2b_first_rise_cycle", 64'(rise1), 64'd1);
    check("b2b_rise_spacing", 64'(rise2 - rise1), 64'd4);
    check("b2b_rise_count", 64'(rise_cnt), 64'd2);
    check("b2b_end_idle", CMD_READY, 1'b1);

    // Response stall: RSP_READY low for ten cycles while a new command waits.
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = 32'h0200_0040;
    tick();
    CMD_ADDR  = 32'h0700_0000;
    tick();
    PREADY = 1'b1;
    PRDATA = 32'h5555_AAAA;
    tick();
    PREADY = 1'b0;
    PRDATA = 32'h0;
    check("stall_rsp_valid", RSP_VALID, 1'b1);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(RSP_VALID === 1'b1 && RSP_RDATA === 32'h5555_AAAA && RSP_ERR === 2'b00
            && CMD_READY === 1'b0 && PSEL === 16'h0 && PADDR === 32'h0200_0040))
        stable_ok = 1'b0;
    end
    check("stall_stable", stable_ok, 1'b1);
    CMD_VALID = 1'b0;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    check("stall_release_rsp_valid", RSP_VALID, 1'b0);
    check("stall_release_cmd_ready", CMD_READY, 1'b1);

    // Reset during ACCESS: bus and response clear at once, nothing emerges later.
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b1;
    CMD_ADDR  = 32'h0400_0000;
    CMD_WDATA = 32'h0000_0077;
    tick();
    CMD_VALID = 1'b0;
    tick();
    check("mid_rst_in_access", PENABLE, 1'b1);
    #1 PRESETN = 1'b0;
    #1;
    check("mid_rst_psel", PSEL, 16'h0000);
    check("mid_rst_penable", PENABLE, 1'b0);
    check("mid_rst_rsp_valid", RSP_VALID, 1'b0);
    check("mid_rst_cmd_ready", CMD_READY, 1'b0);
    check("mid_rst_paddr", PADDR, 32'h0);
    tick();
    tick();
    #2 PRESETN = 1'b1;
    PREADY = 1'b1;
    seen_activity = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (RSP_VALID !== 1'b0 || PSEL !== 16'h0) seen_activity = 1'b1;
    end
    PREADY = 1'b0;
    check("post_rst_no_response", seen_activity, 1'b0);
    xfer("post_rst", 1'b0, 32'h0600_0008, 32'h0, 1, 32'h0F0F_0F0F, 1'b0,
         16'h0040, 2'b00, 32'h0F0F_0F0F, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
